seg7_time_display: RTL and testbench

//  Display end of the counter_commander time bus: samples min/sec/ms_10 once per scan frame,

---
 rtl/seg7_time_display.sv | 171 +++++++++++++++++
 tb/tb_seg7_time_display.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seg7_time_display.sv
// Four-digit multiplexed seven-segment display for the min/sec/hundredths time bus.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank the leftmost digit when it is zero).
module seg7_time_display #(
  parameter int SCAN_DIV = 2500
) (
  input  logic        clk_core,
  input  logic        rst,
  input  logic [5:0]  min_i,
  input  logic [5:0]  sec_i,
  input  logic [6:0]  ms_10_i,
  input  logic        display_switch,
  output logic [10:0] seven_segment_display_o
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {IDLE, CONV_A, CONV_B, DONE} state_t;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  logic [CW-1:0]   scan_cnt_r;
  logic [1:0]      digit_idx_r;
  state_t          state_r, state_nx_s;
  logic [6:0]      work_r, cap_b_r;
  logic [3:0]      tens_r, tens_a_r, ones_a_r, tens_b_r, ones_b_r;
  logic            bad_a_r, bad_b_r;
  logic [3:0][6:0] buf_r, disp_r;
  logic [10:0]     out_r;
  logic            frame_end_s;
  logic [6:0]      d3_seg_s;
  logic [3:0]      anode_s;

  assign frame_end_s = (digit_idx_r == 2'd3) && (scan_cnt_r == CW'(SCAN_DIV - 1));
  assign anode_s     = ~(4'b0001 << digit_idx_r);
  assign seven_segment_display_o = out_r;

  // Slot timer and digit index.
  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) begin
      scan_cnt_r  <= '0;
      digit_idx_r <= 2'd0;
    end else if (scan_cnt_r == CW'(SCAN_DIV - 1)) begin
      scan_cnt_r  <= '0;
      digit_idx_r <= digit_idx_r + 2'd1;
    end else begin
      scan_cnt_r  <= scan_cnt_r + CW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_nx_s;
  end

  // FSM next state: each conversion phase ends once the remainder drops below ten.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (frame_end_s) state_nx_s = CONV_A;
        else             state_nx_s = IDLE;
      end
      CONV_A: begin
        if (bad_a_r || (work_r < 7'd10)) state_nx_s = CONV_B;
        else                             state_nx_s = CONV_A;
      end
      CONV_B: begin
        if (bad_b_r || (work_r < 7'd10)) state_nx_s = DONE;
        else                             state_nx_s = CONV_B;
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Leftmost digit rendering (tens of field A).
  always_comb begin
    d3_seg_s = SEG_BLANK;
    if (bad_a_r) begin
      d3_seg_s = SEG_DASH;
    end else begin
`ifdef LEADING_ZERO_BLANK_EN
      d3_seg_s = (tens_a_r == 4'd0) ? SEG_BLANK : seg_of(tens_a_r);
`else
      d3_seg_s = seg_of(tens_a_r);
`endif
    end
  end

  // Capture, subtract-10 conversion and buffer/display commit.
  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) begin
      work_r   <= 7'd0;
      cap_b_r  <= 7'd0;
      tens_r   <= 4'd0;
      tens_a_r <= 4'd0;
      ones_a_r <= 4'd0;
      tens_b_r <= 4'd0;
      ones_b_r <= 4'd0;
      bad_a_r  <= 1'b0;
      bad_b_r  <= 1'b0;
      buf_r    <= {4{SEG_BLANK}};
      disp_r   <= {4{SEG_BLANK}};
    end else if (frame_end_s) begin
      disp_r  <= buf_r;
      work_r  <= display_switch ? {1'b0, sec_i} : {1'b0, min_i};
      cap_b_r <= display_switch ? ms_10_i : {1'b0, sec_i};
      bad_a_r <= (display_switch ? sec_i : min_i) > 6'd59;
      bad_b_r <= display_switch ? (ms_10_i > 7'd99) : (sec_i > 6'd59);
      tens_r  <= 4'd0;
    end else begin
      case (state_r)
        CONV_A: begin
          if (!bad_a_r && (work_r >= 7'd10)) begin
            work_r <= work_r - 7'd10;
            tens_r <= tens_r + 4'd1;
          end else begin
            tens_a_r <= tens_r;
            ones_a_r <= work_r[3:0];
            work_r   <= cap_b_r;
            tens_r   <= 4'd0;
          end
        end
        CONV_B: begin
          if (!bad_b_r && (work_r >= 7'd10)) begin
            work_r <= work_r - 7'd10;
            tens_r <= tens_r + 4'd1;
          end else begin
            tens_b_r <= tens_r;
            ones_b_r <= work_r[3:0];
          end
        end
        DONE: begin
          buf_r[3] <= d3_seg_s;
          buf_r[2] <= bad_a_r ? SEG_DASH : seg_of(ones_a_r);
          buf_r[1] <= bad_b_r ? SEG_DASH : seg_of(tens_b_r);
          buf_r[0] <= bad_b_r ? SEG_DASH : seg_of(ones_b_r);
        end
        default: begin
          work_r <= work_r;
        end
      endcase
    end
  end

  // Registered pin drive for the active slot.
  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) out_r <= 11'h7FF;
    else      out_r <= {anode_s, disp_r[digit_idx_r]};
  end

endmodule

// File: tb/tb_seg7_time_display.sv
// Scoreboard bench for seg7_time_display with SCAN_DIV=8 (32-cycle frames).
module tb_seg7_time_display;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S7 = 7'b1111000, S9 = 7'b0010000,
                         DS = 7'b0111111, BL = 7'b1111111;

  logic        clk_core = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  min_i = 6'd63;
  logic [5:0]  sec_i = 6'd63;
  logic [6:0]  ms_10_i = 7'd127;
  logic        display_switch = 1'b1;
  logic [10:0] seg_o;

  typedef struct {
    int          tag;
    logic [10:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int   tcyc = 0;
  int   n_pass = 0;
  int   n_checks = 0;
  int   rel = 0;

  seg7_time_display #(.SCAN_DIV(8)) dut (
    .clk_core(clk_core), .rst(rst), .min_i(min_i), .sec_i(sec_i),
    .ms_10_i(ms_10_i), .display_switch(display_switch),
    .seven_segment_display_o(seg_o)
  );

  always #5 clk_core = ~clk_core;
  always @(posedge clk_core) tcyc <= tcyc + 1;

  function automatic void push(input int tag, input logic [10:0] e, input string nm);
    chk_t c;
    c.tag = tag; c.exp = e; c.name = nm;
    q.push_back(c);
  endfunction

  task automatic compare(input chk_t c);
    n_checks++;
    if (seg_o === c.exp) n_pass++;
    else $display("FAIL %s: got %b required %b (t=%0t)", c.name, seg_o, c.exp, $time);
  endtask

  // Clocked monitor: checks entries tagged for the current cycle.
  always @(negedge clk_core) begin
    chk_t c;
    while (q.size() > 0 && q[0].tag >= 0 && q[0].tag <= tcyc) begin
      c = q.pop_front();
      if (c.tag < tcyc) begin
        n_checks++;
        $display("FAIL %s: got no sample required %b", c.name, c.exp);
      end else begin
        compare(c);
      end
    end
  end

  // Reset-edge monitor: checks the output right after an asynchronous reset.
  always @(negedge rst) begin
    chk_t c2;
    #1;
    if (q.size() > 0 && q[0].tag < 0) begin
      c2 = q.pop_front();
      compare(c2);
    end
  end

  task automatic expect_frame(input int f, input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0, input string tn);
    logic [6:0] s [4];
    logic [3:0] an [4];
    s  = '{s0, s1, s2, s3};
    an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int d = 0; d < 4; d++)
      push(rel + 32 * f + 8 * d + 4, {an[d], s[d]}, $sformatf("%s_f%0d_d%0d", tn, f, d));
  endtask

  task automatic do_reset();
    @(negedge clk_core);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) push(tcyc + i, 11'h7FF, "reset_hold");
    repeat (5) @(negedge clk_core);
    rst = 1'b1;
    rel = tcyc;
    expect_frame(0, BL, BL, BL, BL, "blank");
    expect_frame(1, BL, BL, BL, BL, "blank");
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && q.size() > 0; i++) @(negedge clk_core);
    if (q.size() > 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d pending, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic wait_until(input int target);
    while (tcyc < target) @(negedge clk_core);
  endtask

  initial begin
    // MM SS page
    min_i = 6'd12; sec_i = 6'd34; display_switch = 1'b0;
    do_reset();
    expect_frame(2, S1, S2, S3, S4, "mmss");
    drain();

    // SS cc page, leading zero
    sec_i = 6'd5; ms_10_i = 7'd99; display_switch = 1'b1;
    do_reset();
`ifdef LEADING_ZERO_BLANK_EN
    expect_frame(2, BL, S5, S9, S9, "sscc");
`else
    expect_frame(2, S0, S5, S9, S9, "sscc");
`endif
    drain();

    // out-of-range hundredths
    sec_i = 6'd7; ms_10_i = 7'd100; display_switch = 1'b1;
    do_reset();
    expect_frame(2, S0, S7, DS, DS, "ms_oor");
    drain();

    // out-of-range minutes
    min_i = 6'd60; sec_i = 6'd34; display_switch = 1'b0;
    do_reset();
    expect_frame(2, DS, DS, S3, S4, "min_oor");
    drain();

    // mid-frame input change and page toggle
    min_i = 6'd12; sec_i = 6'd34; display_switch = 1'b0;
    do_reset();
    expect_frame(2, S1, S2, S3, S4, "mid_cur");
    expect_frame(3, S1, S2, S3, S4, "mid_next");
    expect_frame(4, S4, S5, S3, S4, "mid_new");
    wait_until(rel + 64 + 12);
    min_i = 6'd45; display_switch = 1'b1;
    wait_until(rel + 64 + 20);
    display_switch = 1'b0;
    drain();

    // asynchronous reset during conversion
    wait_until(rel + 162);
    push(-1, 11'h7FF, "async_rst");
    #2 rst = 1'b0;
    repeat (3) @(negedge clk_core);
    rst = 1'b1;
    rel = tcyc;
    expect_frame(0, BL, BL, BL, BL, "post_rst");
    expect_frame(1, BL, BL, BL, BL, "post_rst");
    expect_frame(2, S4, S5, S3, S4, "post_rst");
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
